conv_window_gen: RTL and testbench

CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

---
 rtl/conv_pkg.sv | 13 +
 rtl/line_buffer.sv | 27 ++
 rtl/conv_window_gen.sv | 112 +++++++++++
 tb/tb_conv_window_gen.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared convolution constants: kernel size and the 3x3 window element packing
// used by both the window generator and the PE array.
package conv_pkg;

    localparam int KERNEL_SIZE = 3;
    localparam int WIN_ELEMS   = KERNEL_SIZE * KERNEL_SIZE;

    // Element (r,c) lives at slot 3*r+c; r=0 is the oldest row, c=0 the leftmost column.
    function automatic int win_idx(input int r, input int c);
        return KERNEL_SIZE * r + c;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of delay: an enable-gated shift register whose tap returns the
// pixel pushed DEPTH enables ago (same column, previous row).
module line_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] tap
);

    // Storage is deliberately unreset; stale contents are never emitted as a window.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign tap = mem[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Streams raster pixels from a FWFT FIFO and emits 3x3 windows (centre in raster
// order) with a valid/ready output that holds steady under backpressure.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH-1:0]           fifo_data,
    input  logic                            fifo_empty,
    output logic                            fifo_rd_en,
    output logic [WIN_ELEMS*DATA_WIDTH-1:0] win_data,
    output logic                            win_valid,
    input  logic                            win_ready,
    output logic                            win_last
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    // Handshake: a window transfers on a cycle with win_valid && win_ready; a pixel is
    // popped whenever the FIFO has data and the output register is free or draining.
    logic pop;
    assign pop        = !rst && !fifo_empty && (!win_valid || win_ready);
    assign fifo_rd_en = pop;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          at_end_col;
    logic          at_end_row;
    logic          produce;

    assign at_end_col = (col == CW'(IMG_WIDTH - 1));
    assign at_end_row = (row == RW'(IMG_HEIGHT - 1));
    assign produce    = pop && (row >= RW'(2)) && (col >= CW'(2));

    logic [DATA_WIDTH-1:0] tap_prev;
    logic [DATA_WIDTH-1:0] tap_prev2;

    line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb_prev (
        .clk (clk),
        .en  (pop),
        .din (fifo_data),
        .tap (tap_prev)
    );

    line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb_prev2 (
        .clk (clk),
        .en  (pop),
        .din (tap_prev),
        .tap (tap_prev2)
    );

    logic [DATA_WIDTH-1:0]           sw     [KERNEL_SIZE][KERNEL_SIZE];
    logic [DATA_WIDTH-1:0]           nxt    [KERNEL_SIZE][KERNEL_SIZE];
    logic [DATA_WIDTH-1:0]           new_col[KERNEL_SIZE];
    logic [WIN_ELEMS*DATA_WIDTH-1:0] nxt_flat;

    always_comb begin
        new_col[0] = tap_prev2;
        new_col[1] = tap_prev;
        new_col[2] = fifo_data;
        nxt_flat   = '0;
        for (int r = 0; r < KERNEL_SIZE; r++) begin
            for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
                nxt[r][c] = sw[r][c+1];
            end
            nxt[r][KERNEL_SIZE-1] = new_col[r];
            for (int c = 0; c < KERNEL_SIZE; c++) begin
                nxt_flat[DATA_WIDTH*win_idx(r, c) +: DATA_WIDTH] = nxt[r][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            sw <= nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            win_data  <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else begin
            if (pop) begin
                if (at_end_col) begin
                    col <= '0;
                    row <= at_end_row ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
            // A producing pop replaces an accepted window in the same cycle (no bubble).
            if (produce) begin
                win_data  <= nxt_flat;
                win_valid <= 1'b1;
                win_last  <= at_end_col && at_end_row;
            end else if (win_valid && win_ready) begin
                win_valid <= 1'b0;
                win_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on a 4x4 image: hand-computed window table,
// stall, back-to-back frames, FIFO bubbles and mid-frame reset.
module tb_conv_window_gen;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int STALL_LEN = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] fifo_data;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [9*DW-1:0] win_data;
    logic          win_valid;
    logic          win_ready;
    logic          win_last;

    conv_window_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .win_data   (win_data),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_last   (win_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] px [9];
        bit            last;
    } vec_t;

    vec_t            tbl [8];
    logic [9*DW:0]   exp_q [$];
    logic [DW-1:0]   src_q [$];
    logic [DW-1:0]   fr [H][W];
    int              hs_cyc [$];
    int              n_checks = 0;
    int              n_pass   = 0;
    int              n_last   = 0;
    int              cyc      = 0;
    int              first_pop = -1;
    int              stall_left = 0;
    logic [9*DW-1:0] held;

    task automatic chk(input string name, input logic [9*DW:0] act, input logic [9*DW:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [9*DW:0] pack_vec(input vec_t v);
        logic [9*DW:0] p;
        p = '0;
        for (int i = 0; i < 9; i++) p[DW*i +: DW] = v.px[i];
        p[9*DW] = v.last;
        return p;
    endfunction

    task automatic push_seq(input int base);
        for (int i = 0; i < W*H; i++) src_q.push_back(DW'(base + i));
    endtask

    task automatic expect_tbl(input int first, input int cnt);
        for (int k = first; k < first + cnt; k++) exp_q.push_back(pack_vec(tbl[k]));
    endtask

    // Reference windows straight from the 2-D frame: centre raster order, r=0 oldest row.
    task automatic push_random_frame();
        logic [9*DW:0] p;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                fr[r][c] = DW'($urandom_range(0, 255));
                src_q.push_back(fr[r][c]);
            end
        for (int r = 2; r < H; r++)
            for (int c = 2; c < W; c++) begin
                p = '0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        p[DW*(3*i+j) +: DW] = fr[r-2+i][c-2+j];
                p[9*DW] = (r == H-1) && (c == W-1);
                exp_q.push_back(p);
            end
    endtask

    task automatic step(input int bubble_pct);
        bit stalling;
        @(negedge clk);
        stalling  = (stall_left > 0) && win_valid;
        win_ready = !stalling;
        if (src_q.size() != 0 && $urandom_range(0, 99) >= bubble_pct) begin
            fifo_empty = 1'b0;
            fifo_data  = src_q[0];
        end else begin
            fifo_empty = 1'b1;
            fifo_data  = '0;
        end
        #1;
        chk("rd_en_rule", fifo_rd_en, !fifo_empty && (!win_valid || win_ready));
        if (stalling) begin
            if (stall_left == STALL_LEN) held = win_data;
            else chk("stall_data", win_data, held);
            chk("stall_rd_en", fifo_rd_en, 1'b0);
            chk("stall_valid", win_valid, 1'b1);
            stall_left--;
        end
        if (win_valid && win_ready) begin
            hs_cyc.push_back(cyc);
            if (win_last) n_last++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL extra_window: got %h expected none", win_data);
            end else begin
                chk("window", {win_last, win_data}, exp_q.pop_front());
            end
        end
        if (fifo_rd_en) begin
            if (first_pop < 0) first_pop = cyc;
            void'(src_q.pop_front());
        end
        cyc++;
    endtask

    task automatic drain(input string name, input int budget, input int bubble_pct);
        int n;
        n = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            step(bubble_pct);
            n++;
        end
        chk({name, "_exp_left"}, exp_q.size(), 0);
        chk({name, "_src_left"}, src_q.size(), 0);
        repeat (3) step(0);
        exp_q.delete();
        src_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0].px = '{0, 1, 2, 4, 5, 6, 8, 9, 10};          tbl[0].last = 0;
        tbl[1].px = '{1, 2, 3, 5, 6, 7, 9, 10, 11};         tbl[1].last = 0;
        tbl[2].px = '{4, 5, 6, 8, 9, 10, 12, 13, 14};       tbl[2].last = 0;
        tbl[3].px = '{5, 6, 7, 9, 10, 11, 13, 14, 15};      tbl[3].last = 1;
        tbl[4].px = '{100, 101, 102, 104, 105, 106, 108, 109, 110}; tbl[4].last = 0;
        tbl[5].px = '{101, 102, 103, 105, 106, 107, 109, 110, 111}; tbl[5].last = 0;
        tbl[6].px = '{104, 105, 106, 108, 109, 110, 112, 113, 114}; tbl[6].last = 0;
        tbl[7].px = '{105, 106, 107, 109, 110, 111, 113, 114, 115}; tbl[7].last = 1;

        // Reset state, with FIFO showing data so the pop gate is exercised.
        rst = 1'b1; fifo_empty = 1'b1; fifo_data = '0; win_ready = 1'b1;
        repeat (2) @(negedge clk);
        fifo_empty = 1'b0; fifo_data = 8'hA5;
        #1;
        chk("rst_win_valid", win_valid, 1'b0);
        chk("rst_win_last",  win_last,  1'b0);
        chk("rst_win_data",  win_data,  '0);
        chk("rst_rd_en",     fifo_rd_en, 1'b0);
        @(negedge clk);
        rst = 1'b0; fifo_empty = 1'b1;

        // Basic frame plus latency / throughput of a continuous stream.
        hs_cyc.delete(); first_pop = -1; n_last = 0;
        push_seq(0); expect_tbl(0, 4);
        drain("basic", 200, 0);
        chk("basic_hs_count", hs_cyc.size(), 4);
        if (hs_cyc.size() == 4) begin
            chk("basic_latency",  hs_cyc[0] - first_pop, 11);
            chk("basic_row2_gap", hs_cyc[1] - hs_cyc[0], 1);
            chk("basic_row_gap",  hs_cyc[2] - hs_cyc[1], 3);
            chk("basic_row3_gap", hs_cyc[3] - hs_cyc[2], 1);
        end
        chk("basic_last_count", n_last, 1);

        // Backpressure on the first window.
        stall_left = STALL_LEN;
        push_seq(0); expect_tbl(0, 4);
        drain("stall", 200, 0);
        chk("stall_consumed", stall_left, 0);

        // Back-to-back frames: the 5th window must hold only frame-2 data.
        push_seq(0); push_seq(100); expect_tbl(0, 8);
        drain("b2b", 300, 0);

        // Random FIFO bubbles over four random frames.
        n_last = 0;
        for (int f = 0; f < 4; f++) push_random_frame();
        drain("bubble", 2000, 50);
        chk("bubble_last_count", n_last, 4);

        // Reset mid-frame after pixel 9, then a full clean frame.
        for (int i = 0; i < 10; i++) src_q.push_back(DW'(i));
        drain("pre_rst", 100, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rst = 1'b1; fifo_empty = 1'b0; fifo_data = 8'h55; win_ready = 1'b1;
            #1;
            chk("midrst_win_valid", win_valid, 1'b0);
            chk("midrst_win_last",  win_last,  1'b0);
            chk("midrst_win_data",  win_data,  '0);
            chk("midrst_rd_en",     fifo_rd_en, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0; fifo_empty = 1'b1;
        hs_cyc.delete();
        push_seq(0); expect_tbl(0, 4);
        drain("post_rst", 200, 0);
        chk("post_rst_hs_count", hs_cyc.size(), 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
